bitwise_logic_pipe: RTL and testbench

Parametrised, handshaked bitwise logic unit. Successor to the fixed-width combinational XOR datapath.
- Per-beat operations: XOR, AND, OR, XNOR.
- Multi-beat XOR-accumulate mode (checksum/fold).
- Registered results are buffered in a small output FIFO, so the producer and consumer decouple under backpressure.

---
 rtl/bitwise_logic_pipe_if.sv | 38 +++
 rtl/bitwise_logic_pipe.sv | 145 ++++++++++++++
 tb/tb_bitwise_logic_pipe.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/bitwise_logic_pipe_if.sv
// Handshake bundle for bitwise_logic_pipe: input beat channel, output result channel, status flags.
// With BITWISE_LOGIC_PIPE_PARITY_EN defined, the result channel also carries out_parity.
interface bitwise_logic_pipe_if #(
  parameter int WIDTH = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             acc_active;
  logic             err;
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
  logic             out_parity;
`endif

  // Producer/consumer side (drives beats, accepts results)
  modport master (
    output in_valid, in_a, in_b, in_mode, in_last, out_ready,
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
    input  out_parity,
`endif
    input  in_ready, out_valid, out_data, acc_active, err
  );

  // Logic unit side
  modport slave (
    input  in_valid, in_a, in_b, in_mode, in_last, out_ready,
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
    output out_parity,
`endif
    output in_ready, out_valid, out_data, acc_active, err
  );
endinterface

// File: rtl/bitwise_logic_pipe.sv
// Handshaked bitwise logic unit (XOR/AND/OR/XNOR, XOR-accumulate) feeding a small output FIFO.
// Optional macro BITWISE_LOGIC_PIPE_PARITY_EN adds a stored per-entry parity bit and out_parity.
module bitwise_logic_pipe #(
  parameter int WIDTH      = 20,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst_n,
  bitwise_logic_pipe_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  // Mode decode
  logic op_and;
  logic op_or;
  logic op_xnor;
  logic op_acc;
  logic op_rsvd;

  assign op_and  = (bus.in_mode == 3'd1);
  assign op_or   = (bus.in_mode == 3'd2);
  assign op_xnor = (bus.in_mode == 3'd3);
  assign op_acc  = (bus.in_mode == 3'd4);
  assign op_rsvd = (bus.in_mode >= 3'd5);

  // State
  logic [WIDTH-1:0] acc_reg;
  logic             acc_active_reg;
  logic             err_reg;
  logic             in_ready_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;

  logic [EW-1:0]    mem [FIFO_DEPTH];

  // Datapath
  logic [WIDTH-1:0] beat_res;
  logic [WIDTH-1:0] acc_sum;
  logic [WIDTH-1:0] wr_data;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    head_entry;

  // Per-bit operator slice; reserved modes fall through to XOR.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic x_bit;
      assign x_bit = bus.in_a[gi] ^ bus.in_b[gi];
      assign beat_res[gi] = op_and  ? (bus.in_a[gi] & bus.in_b[gi]) :
                            op_or   ? (bus.in_a[gi] | bus.in_b[gi]) :
                            op_xnor ? ~x_bit : x_bit;
      assign acc_sum[gi]  = acc_reg[gi] ^ x_bit;
    end
  endgenerate

  assign wr_data = op_acc ? acc_sum : beat_res;

`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
  assign wr_entry = {^wr_data, wr_data};
`else
  assign wr_entry = wr_data;
`endif

  // Handshake
  logic accept;
  logic push;
  logic pop;
  logic fifo_nonempty;

  assign fifo_nonempty = (count_reg != '0);
  assign accept        = bus.in_valid && in_ready_reg;
  // Accumulating beats (ACC_XOR without last) never occupy a FIFO slot.
  assign push          = accept && (!op_acc || bus.in_last);
  assign pop           = fifo_nonempty && bus.out_ready;

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg        <= '0;
      acc_active_reg <= 1'b0;
      err_reg        <= 1'b0;
      in_ready_reg   <= 1'b0;
      count_reg      <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
    end else begin
      count_reg    <= count_next;
      // Derived from the next count so a pop while full re-opens input one cycle later.
      in_ready_reg <= (count_next != CW'(FIFO_DEPTH));
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (accept && op_acc) begin
        if (bus.in_last) begin
          acc_reg        <= '0;
          acc_active_reg <= 1'b0;
        end else begin
          acc_reg        <= acc_sum;
          acc_active_reg <= 1'b1;
        end
      end
      if (accept && op_rsvd) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Storage has no reset; stale contents are masked by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  assign head_entry = mem[rd_ptr_reg];

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = fifo_nonempty;
  assign bus.out_data   = fifo_nonempty ? head_entry[WIDTH-1:0] : '0;
  assign bus.acc_active = acc_active_reg;
  assign bus.err        = err_reg;
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
  assign bus.out_parity = fifo_nonempty ? head_entry[WIDTH] : 1'b0;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: directed beats push expected results, a negedge monitor pops and compares.
module tb_bitwise_logic_pipe;
  localparam int W = 20;
  localparam int D = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitwise_logic_pipe_if #(.WIDTH(W)) bus ();

  bitwise_logic_pipe #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%05h required 0x%05h", name, act, req);
    end
  endtask

  // Monitor: one comparison per output handshake
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stale_output: got 0x%05h required no output", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("scoreboard_data", bus.out_data, e);
`ifdef BITWISE_LOGIC_PIPE_PARITY_EN
        chk("scoreboard_parity", W'(bus.out_parity), W'(^e));
`endif
        $display("out data=0x%05h expected=0x%05h", bus.out_data, e);
      end
    end
  end

  // Drive one beat; wait (bounded) for in_ready, then record the expected result if it produces output.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] mode,
                      input logic last, input logic pushes, input logic [W-1:0] exp);
    int waited = 0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_mode = mode;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready=0 required 1 within 100 cycles");
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (pushes) exp_q.push_back(exp);
    #1;
    bus.in_valid = 1'b0;
    $display("in  mode=%0d a=0x%05h b=0x%05h last=%0d", mode, a, b, last);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
    chk("drained_out_valid", W'(bus.out_valid), W'(0));
  endtask

  logic [W-1:0] mode_a   [4] = '{20'hABCDE, 20'hABCDE, 20'hABCDE, 20'hABCDE};
  logic [W-1:0] mode_b   [4] = '{20'h12345, 20'h12345, 20'h12345, 20'h12345};
  logic [W-1:0] mode_exp [4] = '{20'hB9F9B, 20'h02044, 20'hBBFDF, 20'h46064};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_mode = '0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_in_ready", W'(bus.in_ready), W'(1));
    chk("reset_out_valid", W'(bus.out_valid), W'(0));
    chk("reset_out_data", bus.out_data, W'(0));
    chk("reset_acc_active", W'(bus.acc_active), W'(0));
    chk("reset_err", W'(bus.err), W'(0));

    // Per-beat modes, latency 1
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pre_accept_out_valid", W'(bus.out_valid), W'(0));
      send(mode_a[i], mode_b[i], 3'(i), 1'b0, 1'b1, mode_exp[i]);
      chk("lat1_out_valid", W'(bus.out_valid), W'(1));
      chk("lat1_out_data", bus.out_data, mode_exp[i]);
      @(posedge clk);
      #1;
    end

    // Backpressure: third beat held until the consumer drains
    bus.out_ready = 1'b0;
    send(20'h11111, 20'h00000, 3'd0, 1'b0, 1'b1, 20'h11111);
    send(20'h22222, 20'h00000, 3'd0, 1'b0, 1'b1, 20'h22222);
    chk("full_in_ready", W'(bus.in_ready), W'(0));
    fork
      send(20'h33333, 20'h00000, 3'd0, 1'b0, 1'b1, 20'h33333);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_out_data_stable", bus.out_data, 20'h11111);
          chk("stall_in_ready", W'(bus.in_ready), W'(0));
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Accumulate frame with an interleaved XOR beat (in_last ignored there)
    send(20'h00001, 20'h00002, 3'd4, 1'b0, 1'b0, '0);
    chk("acc_active_after_first", W'(bus.acc_active), W'(1));
    chk("acc_no_output_1", W'(bus.out_valid), W'(0));
    send(20'h00004, 20'h00008, 3'd4, 1'b0, 1'b0, '0);
    chk("acc_no_output_2", W'(bus.out_valid), W'(0));
    send(20'h00F00, 20'h000F0, 3'd0, 1'b1, 1'b1, 20'h00FF0);
    chk("acc_active_interleave", W'(bus.acc_active), W'(1));
    drain();
    send(20'h00010, 20'h00000, 3'd4, 1'b1, 1'b1, 20'h0001F);
    chk("acc_active_after_last", W'(bus.acc_active), W'(0));
    chk("acc_result", bus.out_data, 20'h0001F);
    drain();

    // Single-beat frame
    send(20'h00001, 20'h00000, 3'd4, 1'b1, 1'b1, 20'h00001);
    drain();

    // Reserved mode: XOR result, sticky err
    send(20'hFFFFF, 20'h0000F, 3'd5, 1'b0, 1'b1, 20'hFFFF0);
    chk("err_set", W'(bus.err), W'(1));
    send(20'hABCDE, 20'h12345, 3'd0, 1'b0, 1'b1, 20'hB9F9B);
    chk("err_sticky", W'(bus.err), W'(1));
    drain();

    // Mid-frame, mid-backpressure asynchronous reset
    bus.out_ready = 1'b0;
    send(20'h00003, 20'h00000, 3'd4, 1'b0, 1'b0, '0);
    send(20'h55555, 20'h00000, 3'd0, 1'b0, 1'b1, 20'h55555);
    send(20'hAAAAA, 20'h00000, 3'd6, 1'b0, 1'b1, 20'hAAAAA);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("async_rst_out_valid", W'(bus.out_valid), W'(0));
    chk("async_rst_out_data", bus.out_data, W'(0));
    chk("async_rst_acc_active", W'(bus.acc_active), W'(0));
    chk("async_rst_err", W'(bus.err), W'(0));
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", W'(bus.in_ready), W'(1));
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_stale", W'(bus.out_valid), W'(0));
    // Accumulator must restart from zero
    send(20'h00100, 20'h00000, 3'd4, 1'b1, 1'b1, 20'h00100);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
